cdc_2phase_src_arb: RTL and testbench

- Round-robin arbiter that shares one two-phase CDC channel among NumIn requesters in the source clock domain.
- Accepts one beat per grant and tags it with the winner index, giving {idx, data} to the downstream CDC source side.
- Holds the beat stable in an output register until the CDC accepts it.
- Counts completed transfers and provides a flush/drain control, so software can quiesce the channel before a CDC clear.

---
 rtl/cdc_arb_pkg.sv | 13 +
 rtl/cdc_2phase_src_arb_rr_pick.sv | 32 +++
 rtl/cdc_2phase_src_arb.sv | 99 +++++++++
 tb/tb_cdc_2phase_src_arb.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_arb_pkg.sv
// Shared types and helpers for the CDC source-side arbiters.
package cdc_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdc_2phase_src_arb_rr_pick.sv
// Combinational round-robin picker: first valid at or above ptr, wrapping to 0.
module rr_pick #(
    parameter int NumIn    = 4,
    parameter int IdxWidth = 2
) (
    input  logic [NumIn-1:0]    valid,
    input  logic [IdxWidth-1:0] ptr,
    output logic [NumIn-1:0]    grant,
    output logic [IdxWidth-1:0] idx,
    output logic                any
);

    int j;

    // Walk from the farthest candidate back toward ptr so the closest valid wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = NumIn - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NumIn;
            if (valid[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IdxWidth'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdc_2phase_src_arb.sv
// Round-robin arbiter feeding one beat register toward a two-phase CDC source,
// with handshake counting and a flush control for quiescing the channel.
//
//   state | meaning
//   IDLE  | output register empty, cdc_valid_o low
//   SEND  | output register holds {idx, data}, cdc_valid_o high
module cdc_2phase_src_arb
    import cdc_arb_pkg::*;
#(
    parameter int NumIn     = 4,
    parameter int DataWidth = 32,
    parameter int CntWidth  = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumIn-1:0]               req_valid_i,
    input  logic [NumIn*DataWidth-1:0]     req_data_i,
    output logic [NumIn-1:0]               req_ready_o,
    input  logic                           flush_i,
    output logic                           cdc_valid_o,
    output logic [idx_width(NumIn)-1:0]    cdc_idx_o,
    output logic [DataWidth-1:0]           cdc_data_o,
    input  logic                           cdc_ready_i,
    output logic                           idle_o,
    output logic [CntWidth-1:0]            txn_cnt_o
);

    localparam int IdxWidth = idx_width(NumIn);

    state_e                state_q, state_d;
    logic [IdxWidth-1:0]   rr_ptr_q, ptr_next;
    logic [IdxWidth-1:0]   idx_q;
    logic [DataWidth-1:0]  data_q;
    logic [CntWidth-1:0]   cnt_q;

    logic [NumIn-1:0]      pick_grant;
    logic [IdxWidth-1:0]   pick_idx;
    logic                  pick_any;
    logic                  can_load, accept, handshake;

    rr_pick #(
        .NumIn    (NumIn),
        .IdxWidth (IdxWidth)
    ) u_pick (
        .valid (req_valid_i),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // A full register can be refilled in the same cycle it hands off.
    assign can_load  = !flush_i && (state_q == IDLE || cdc_ready_i);
    assign accept    = can_load && pick_any;
    assign handshake = (state_q == SEND) && cdc_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept)         state_d = SEND;
        else if (handshake) state_d = IDLE;
    end

    always_comb begin
        req_ready_o = accept ? pick_grant : '0;
        cdc_valid_o = (state_q == SEND);
        idle_o      = (state_q == IDLE);
    end

    always_comb begin
        if (int'(pick_idx) >= NumIn - 1) ptr_next = '0;
        else                             ptr_next = pick_idx + IdxWidth'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
        end else begin
            if (accept) begin
                rr_ptr_q <= ptr_next;
                idx_q    <= pick_idx;
                data_q   <= req_data_i[int'(pick_idx)*DataWidth +: DataWidth];
            end
            if (handshake) cnt_q <= cnt_q + CntWidth'(1);
        end
    end

    assign cdc_idx_o  = idx_q;
    assign cdc_data_o = data_q;
    assign txn_cnt_o  = cnt_q;

endmodule

// File: tb/tb_cdc_2phase_src_arb.sv
// Bench for cdc_2phase_src_arb: directed vector table, hand sequences and
// randomized traffic compared against a transaction-level reference model.
module tb_cdc_2phase_src_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int IW = 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [N-1:0]      req_valid_i;
    logic [N*DW-1:0]   req_data_i;
    logic [N-1:0]      req_ready_o;
    logic              flush_i;
    logic              cdc_valid_o;
    logic [IW-1:0]     cdc_idx_o;
    logic [DW-1:0]     cdc_data_o;
    logic              cdc_ready_i;
    logic              idle_o;
    logic [CW-1:0]     txn_cnt_o;

    always #5 clk_i = ~clk_i;

    cdc_2phase_src_arb #(
        .NumIn     (N),
        .DataWidth (DW),
        .CntWidth  (CW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .flush_i     (flush_i),
        .cdc_valid_o (cdc_valid_o),
        .cdc_idx_o   (cdc_idx_o),
        .cdc_data_o  (cdc_data_o),
        .cdc_ready_i (cdc_ready_i),
        .idle_o      (idle_o),
        .txn_cnt_o   (txn_cnt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the beat held for the CDC, the rotating priority start
    // and the handshake count.
    bit            m_send;
    int            m_ptr;
    int            m_idx;
    int            m_cnt;
    logic [DW-1:0] m_data;

    logic [N-1:0]  src_valid;
    logic [DW-1:0] src_data [N];
    int            last_acc;

    typedef struct {
        logic [N-1:0] v;
        bit           fl;
        bit           rdy;
        logic [N-1:0] er;
        bit           ev;
        int           eidx;
        int           ecnt;
    } vec_t;

    vec_t tab[$];
    int   ord[6] = '{0, 1, 2, 3, 0, 1};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        req_valid_i = src_valid;
        for (int i = 0; i < N; i++) req_data_i[i*DW +: DW] = src_data[i];
    endtask

    task automatic step_check();
        int           w;
        bit           cl;
        logic [N-1:0] er;
        drive();
        #1;
        w  = winner(src_valid, m_ptr);
        cl = !flush_i && (!m_send || cdc_ready_i);
        er = (cl && w >= 0) ? (N'(1) << w) : '0;
        check("req_ready", req_ready_o, er);
        check("cdc_valid", cdc_valid_o, m_send);
        check("idle", idle_o, !m_send);
        check("txn_cnt", txn_cnt_o, m_cnt);
        if (m_send) begin
            check("cdc_idx", cdc_idx_o, m_idx);
            check("cdc_data", cdc_data_o, m_data);
        end
    endtask

    task automatic step_clock();
        int w;
        bit acc, hs;
        @(posedge clk_i);
        w   = winner(src_valid, m_ptr);
        acc = !flush_i && (!m_send || cdc_ready_i) && (w >= 0);
        hs  = m_send && cdc_ready_i;
        last_acc = acc ? w : -1;
        if (hs) m_cnt = (m_cnt + 1) % 65536;
        if (acc) begin
            m_send = 1'b1;
            m_idx  = w;
            m_data = src_data[w];
            m_ptr  = (w + 1) % N;
        end else if (hs) begin
            m_send = 1'b0;
        end
        @(negedge clk_i);
    endtask

    task automatic step();
        step_check();
        step_clock();
    endtask

    task automatic do_reset();
        rst_i     = 1'b1;
        src_valid = '0;
        flush_i   = 1'b0;
        drive();
        @(posedge clk_i);
        m_send = 1'b0;
        m_ptr  = 0;
        m_idx  = 0;
        m_cnt  = 0;
        m_data = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic set_pattern_data();
        for (int i = 0; i < N; i++) src_data[i] = 32'hA5A5_0000 | DW'(i);
    endtask

    initial begin
        int guard;
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        cdc_ready_i = 1'b0;
        src_valid   = '0;
        set_pattern_data();
        drive();
        @(negedge clk_i);
        @(negedge clk_i);
        do_reset();

        // reset state
        drive();
        #1;
        check("rst_valid", cdc_valid_o, 1'b0);
        check("rst_idx", cdc_idx_o, 0);
        check("rst_data", cdc_data_o, 0);
        check("rst_idle", idle_o, 1'b1);
        check("rst_ready", req_ready_o, 0);
        check("rst_cnt", txn_cnt_o, 0);

        // single beat, 5-cycle hold, flush drain, then post-flush grants 3 then 0
        tab.push_back('{4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0, 0, 0});
        tab.push_back('{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 2, 0});
        tab.push_back('{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 0, 1});
        tab.push_back('{4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, 0, 1});
        for (int i = 0; i < 4; i++)
            tab.push_back('{4'b1001, 1'b0, 1'b0, 4'b0000, 1'b1, 1, 1});
        tab.push_back('{4'b1001, 1'b1, 1'b0, 4'b0000, 1'b1, 1, 1});
        tab.push_back('{4'b1001, 1'b1, 1'b1, 4'b0000, 1'b1, 1, 1});
        tab.push_back('{4'b1001, 1'b1, 1'b1, 4'b0000, 1'b0, 0, 2});
        tab.push_back('{4'b1001, 1'b0, 1'b1, 4'b1000, 1'b0, 0, 2});
        tab.push_back('{4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1, 3, 2});
        tab.push_back('{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 0, 3});
        tab.push_back('{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 0, 4});

        foreach (tab[i]) begin
            src_valid   = tab[i].v;
            flush_i     = tab[i].fl;
            cdc_ready_i = tab[i].rdy;
            step_check();
            check("tab_ready", req_ready_o, tab[i].er);
            check("tab_valid", cdc_valid_o, tab[i].ev);
            check("tab_idle", idle_o, !tab[i].ev);
            check("tab_cnt", txn_cnt_o, tab[i].ecnt);
            if (tab[i].ev) begin
                check("tab_idx", cdc_idx_o, tab[i].eidx);
                check("tab_data", cdc_data_o, 32'hA5A5_0000 | DW'(tab[i].eidx));
            end
            step_clock();
        end

        // all requesters valid, back-to-back
        do_reset();
        src_valid   = '1;
        cdc_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step_check();
            check("rr_grant", req_ready_o, N'(1) << ord[k]);
            check("rr_cnt", txn_cnt_o, (k == 0) ? 0 : k - 1);
            step_clock();
        end

        // randomized traffic; a requester holds valid and data until accepted
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!src_valid[i] && $urandom_range(0, 1) == 1) begin
                    src_valid[i] = 1'b1;
                    src_data[i]  = $urandom;
                end
            end
            flush_i     = ($urandom_range(0, 9) == 0);
            cdc_ready_i = ($urandom_range(0, 3) != 0);
            step();
            if (last_acc >= 0) src_valid[last_acc] = 1'b0;
        end

        // reset while a beat is held and cdc_ready_i is high
        do_reset();
        set_pattern_data();
        cdc_ready_i = 1'b1;
        src_valid = 4'b0100; step();
        src_valid = 4'b0000; step();
        cdc_ready_i = 1'b0;
        src_valid = 4'b0010; step();
        src_valid = 4'b0000; step();
        check("pre_rst_valid", cdc_valid_o, 1'b1);
        check("pre_rst_cnt", txn_cnt_o, 1);
        cdc_ready_i = 1'b1;
        do_reset();
        drive();
        #1;
        check("mid_rst_valid", cdc_valid_o, 1'b0);
        check("mid_rst_cnt", txn_cnt_o, 0);
        check("mid_rst_idle", idle_o, 1'b1);
        src_valid = '1;
        step_check();
        check("mid_rst_first_grant", req_ready_o, 4'b0001);
        step_clock();

        // counter wrap
        do_reset();
        src_valid   = '1;
        cdc_ready_i = 1'b1;
        guard = 0;
        while (m_cnt != 65535 && guard < 70000) begin
            step();
            guard++;
        end
        drive();
        #1;
        check("cnt_ffff", txn_cnt_o, 16'hFFFF);
        step();
        drive();
        #1;
        check("cnt_wrap", txn_cnt_o, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
